// File: rtl/issue_scheduler_pkg.sv
// Shared processor types seen by the issue scheduler: reservation-station entry,
// common-data-bus broadcast and control bits, plus the default station depth.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

package issue_scheduler_pkg;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 4;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memwr;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
    } control_bits;

    typedef struct packed {
        logic              busy;
        control_bits       ctrl_bits;
        logic [TAG_W-1:0]  tag_1;
        logic [DATA_W-1:0] value_1;
        logic [TAG_W-1:0]  tag_2;
        logic [DATA_W-1:0] value_2;
        logic [TAG_W-1:0]  dest_tag;
    } rs_entry;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb;

    // Loads and stores go to the memory port; everything else to the ALU port.
    function automatic logic is_mem_op(control_bits c);
        return c.memtoreg | c.memwr;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Issue bus between the scheduler (master) and the functional units (slave).
interface issue_scheduler_if
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned PORTS = 2
) ();

    logic [PORTS-1:0] issue_valid;
    rs_entry          issue_entry [PORTS];
    logic [PORTS-1:0] fu_ready;

    modport master (output issue_valid, output issue_entry, input fu_ready);
    modport slave  (input issue_valid, input issue_entry, output fu_ready);

endinterface

// File: rtl/rr_picker.sv
// Round-robin find-first: first set request at or after ptr, wrapping at N-1.
module rr_picker #(
    parameter int unsigned N = 8,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid_c,
    output logic [IDX_W-1:0] gnt_idx_c
);

    int unsigned k;

    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        k           = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!gnt_valid_c && req[IDX_W'(k)]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Picks ready reservation-station entries per issue port and registers them.
// Optional CDB_WAKEUP_BYPASS_EN lets same-cycle CDB broadcasts wake operands.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned RS_ENTRIES = `RS_SIZE,
    parameter int unsigned PORTS      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  rs_entry               res_stations [RS_ENTRIES],
    input  cdb                    cdb1,
    input  cdb                    cdb2,
    input  logic                  flush,
    issue_scheduler_if.master     issue_bus,
    output logic [RS_ENTRIES-1:0] rs_clear
);

    localparam int unsigned IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    logic [PORTS-1:0]      issue_valid_q, issue_valid_d;
    rs_entry               issue_entry_q [PORTS];
    rs_entry               issue_entry_d [PORTS];
    logic [IDX_W-1:0]      rr_ptr_q      [PORTS];
    logic [IDX_W-1:0]      rr_ptr_d      [PORTS];

    rs_entry               resolved_c    [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] ready_c;
    logic [RS_ENTRIES-1:0] req_c         [PORTS];
    logic                  gnt_valid_c   [PORTS];
    logic [IDX_W-1:0]      gnt_idx_c     [PORTS];
    logic [PORTS-1:0]      sel_c;

`ifdef CDB_WAKEUP_BYPASS_EN
    function automatic logic cdb_hit(logic [TAG_W-1:0] t, cdb c);
        return (t != '0) && (t == c.tag);
    endfunction

    // Substitute broadcast values for operands whose producer completes this cycle.
    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            resolved_c[i] = res_stations[i];
            if (cdb_hit(res_stations[i].tag_1, cdb1)) begin
                resolved_c[i].value_1 = cdb1.value;
                resolved_c[i].tag_1   = '0;
            end else if (cdb_hit(res_stations[i].tag_1, cdb2)) begin
                resolved_c[i].value_1 = cdb2.value;
                resolved_c[i].tag_1   = '0;
            end
            if (cdb_hit(res_stations[i].tag_2, cdb1)) begin
                resolved_c[i].value_2 = cdb1.value;
                resolved_c[i].tag_2   = '0;
            end else if (cdb_hit(res_stations[i].tag_2, cdb2)) begin
                resolved_c[i].value_2 = cdb2.value;
                resolved_c[i].tag_2   = '0;
            end
        end
    end
`else
    logic unused_cdb;
    assign unused_cdb = ^{cdb1, cdb2};

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            resolved_c[i] = res_stations[i];
        end
    end
`endif

    // Ready entries split into disjoint per-port request vectors.
    always_comb begin
        ready_c = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            ready_c[i] = resolved_c[i].busy && (resolved_c[i].tag_1 == '0)
                         && (resolved_c[i].tag_2 == '0);
        end
        for (int p = 0; p < PORTS; p++) begin
            req_c[p] = '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                req_c[p][i] = ready_c[i] && (is_mem_op(resolved_c[i].ctrl_bits) ? (p == 1)
                                                                                   : (p == 0));
            end
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        rr_picker #(.N(RS_ENTRIES)) u_pick (
            .req         (req_c[p]),
            .ptr         (rr_ptr_q[p]),
            .gnt_valid_c (gnt_valid_c[p]),
            .gnt_idx_c   (gnt_idx_c[p])
        );
        assign issue_bus.issue_entry[p] = issue_entry_q[p];
    end

    assign issue_bus.issue_valid = issue_valid_q;

    // A port selects only when its register is empty or draining; flush overrides all.
    always_comb begin
        rs_clear      = '0;
        sel_c         = '0;
        issue_valid_d = issue_valid_q;
        for (int p = 0; p < PORTS; p++) begin
            issue_entry_d[p] = issue_entry_q[p];
            rr_ptr_d[p]      = rr_ptr_q[p];
            sel_c[p]         = !flush && (!issue_valid_q[p] || issue_bus.fu_ready[p])
                               && gnt_valid_c[p];
            if (flush) begin
                issue_valid_d[p] = 1'b0;
            end else if (sel_c[p]) begin
                issue_valid_d[p]       = 1'b1;
                issue_entry_d[p]       = resolved_c[gnt_idx_c[p]];
                rr_ptr_d[p]            = (gnt_idx_c[p] == IDX_W'(RS_ENTRIES - 1))
                                         ? '0 : gnt_idx_c[p] + IDX_W'(1);
                rs_clear[gnt_idx_c[p]] = 1'b1;
            end else if (issue_bus.fu_ready[p]) begin
                issue_valid_d[p] = 1'b0;
            end
        end
        if (!reset) begin
            rs_clear = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_q <= '0;
            for (int p = 0; p < PORTS; p++) begin
                issue_entry_q[p] <= '0;
                rr_ptr_q[p]      <= '0;
            end
        end else begin
            issue_valid_q <= issue_valid_d;
            for (int p = 0; p < PORTS; p++) begin
                issue_entry_q[p] <= issue_entry_d[p];
                rr_ptr_q[p]      <= rr_ptr_d[p];
            end
        end
    end

endmodule
